// File: rtl/video_sync_decoder.sv
// Sync-to-position decoder: rebuilds hpos/vpos, visible and frame strobe from
// an incoming hsync/vsync pair, checks the raster timing, and reports lock,
// the measured line length and timing errors. Latency is one clock.
module video_sync_decoder #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_TOTAL      = 800,
    parameter int unsigned H_SYNC_START = 656,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_TOTAL      = 525,
    parameter int unsigned V_SYNC_START = 490,
    parameter int unsigned LOCK_LINES   = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hsync,
    input  logic       i_vsync,
    output logic [9:0] o_hpos,
    output logic [9:0] o_vpos,
    output logic       o_visible,
    output logic       o_frame_strobe,
    output logic       o_locked,
    output logic [9:0] o_line_len,
    output logic       o_error_strobe,
    output logic [7:0] o_err_count
);

    localparam int unsigned POS_W  = 10;
    localparam int unsigned LEN_W  = 10;
    localparam int unsigned ERR_W  = 8;
    localparam int unsigned GOOD_W = $clog2(LOCK_LINES + 1);

    localparam logic [POS_W-1:0]  H_LAST   = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0]  V_LAST   = POS_W'(V_TOTAL - 1);
    localparam logic [POS_W-1:0]  H_START  = POS_W'(H_SYNC_START);
    localparam logic [POS_W-1:0]  V_START  = POS_W'(V_SYNC_START);
    localparam logic [POS_W-1:0]  H_ACT    = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0]  V_ACT    = POS_W'(V_ACTIVE);
    localparam logic [LEN_W-1:0]  H_PERIOD = LEN_W'(H_TOTAL);
    localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
    localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
    localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_LINES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic               hs_q;
    logic               vs_q;
    logic [POS_W-1:0]   hpos_q;
    logic [POS_W-1:0]   hpos_d;
    logic [POS_W-1:0]   vpos_q;
    logic [POS_W-1:0]   vpos_d;
    logic [LEN_W-1:0]   period_q;
    logic [LEN_W-1:0]   period_d;
    logic [GOOD_W-1:0]  good_q;
    logic [LEN_W-1:0]   line_len_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic               locked_q;
    logic               visible_q;
    logic               frame_q;
    logic               err_strobe_q;

    logic               hs_edge;
    logic               vs_edge;
    logic               h_load;
    logic               h_wrap;
    logic               lock_go;
    logic               hsync_fault;
    logic               vsync_fault;
    logic               timing_err;
    logic               locked_d;

    // Edge detection, position of the current sample, and timing checks
    always_comb begin
        hs_edge     = i_hsync & ~hs_q;
        vs_edge     = i_vsync & ~vs_q;
        h_load      = hs_edge && (state_q != LOCKED);
        h_wrap      = (hpos_q == H_LAST) && !h_load;
        lock_go     = (state_q == HLOCK) && vs_edge && (good_q >= LOCK_CNT);

        hpos_d = hpos_q + POS_W'(1);
        if (h_load) begin
            hpos_d = H_START;
        end else if (h_wrap) begin
            hpos_d = '0;
        end

        vpos_d = vpos_q;
        if (lock_go) begin
            vpos_d = V_START;
        end else if (h_wrap) begin
            vpos_d = (vpos_q == V_LAST) ? '0 : vpos_q + POS_W'(1);
        end

        period_d = (period_q == LEN_MAX) ? LEN_MAX : period_q + LEN_W'(1);
        if (hs_edge) begin
            period_d = LEN_W'(1);
        end

        // A misplaced edge and a missing edge both count as an hsync fault
        hsync_fault = hs_edge ? (hpos_d != H_START) : (hpos_d == H_START);
        vsync_fault = vs_edge && (vpos_d != V_START);
        timing_err  = (state_q == LOCKED) && (hsync_fault || vsync_fault);
        locked_d    = lock_go || ((state_q == LOCKED) && !timing_err);
    end

    // Sync delay, position/period counters and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hs_q         <= 1'b0;
            vs_q         <= 1'b0;
            hpos_q       <= '0;
            vpos_q       <= '0;
            period_q     <= '0;
            line_len_q   <= '0;
            err_cnt_q    <= '0;
            locked_q     <= 1'b0;
            visible_q    <= 1'b0;
            frame_q      <= 1'b0;
            err_strobe_q <= 1'b0;
        end else begin
            hs_q         <= i_hsync;
            vs_q         <= i_vsync;
            hpos_q       <= hpos_d;
            vpos_q       <= vpos_d;
            period_q     <= period_d;
            if (hs_edge) begin
                line_len_q <= period_q;
            end
            if (timing_err && (err_cnt_q != ERR_MAX)) begin
                err_cnt_q <= err_cnt_q + ERR_W'(1);
            end
            locked_q     <= locked_d;
            visible_q    <= locked_d && (hpos_d < H_ACT) && (vpos_d < V_ACT);
            frame_q      <= locked_d && (hpos_d == '0) && (vpos_d == '0);
            err_strobe_q <= timing_err;
        end
    end

    // Lock state machine with good-line qualification
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    good_q <= '0;
                    if (hs_edge) begin
                        state_q <= HLOCK;
                    end
                end
                HLOCK: begin
                    if (hs_edge) begin
                        if (period_q == H_PERIOD) begin
                            if (good_q < LOCK_CNT) begin
                                good_q <= good_q + GOOD_W'(1);
                            end
                        end else begin
                            good_q <= '0;
                        end
                    end
                    if (lock_go) begin
                        state_q <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (timing_err) begin
                        state_q <= SEARCH;
                        good_q  <= '0;
                    end
                end
                default: begin
                    state_q <= SEARCH;
                    good_q  <= '0;
                end
            endcase
        end
    end

    assign o_hpos         = hpos_q;
    assign o_vpos         = vpos_q;
    assign o_visible      = visible_q;
    assign o_frame_strobe = frame_q;
    assign o_locked       = locked_q;
    assign o_line_len     = line_len_q;
    assign o_error_strobe = err_strobe_q;
    assign o_err_count    = err_cnt_q;

endmodule

// File: tb/tb_video_sync_decoder.sv
// Scoreboard bench for video_sync_decoder on a reduced 16x7 raster so that
// whole frames, relocks and 300 injected errors fit in a short run.
module tb_video_sync_decoder;

    localparam int HA  = 12;
    localparam int HT  = 16;
    localparam int HSS = 13;
    localparam int HSW = 2;
    localparam int VA  = 4;
    localparam int VT  = 7;
    localparam int VSS = 5;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_hsync = 1'b0;
    logic       i_vsync = 1'b0;
    logic [9:0] o_hpos;
    logic [9:0] o_vpos;
    logic       o_visible;
    logic       o_frame_strobe;
    logic       o_locked;
    logic [9:0] o_line_len;
    logic       o_error_strobe;
    logic [7:0] o_err_count;

    video_sync_decoder #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .LOCK_LINES(4)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_hsync(i_hsync), .i_vsync(i_vsync),
        .o_hpos(o_hpos), .o_vpos(o_vpos), .o_visible(o_visible),
        .o_frame_strobe(o_frame_strobe), .o_locked(o_locked),
        .o_line_len(o_line_len), .o_error_strobe(o_error_strobe),
        .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit zero;
        bit locked;
        bit err;
        int errcnt;
        bit chk_pos;
        int h;
        int v;
        bit chk_len;
        int len;
    } exp_t;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   sample_n = 0;

    // Expected generator-side state
    bit locked_e = 0;
    bit armed    = 0;
    int errcnt_e = 0;
    int gv       = 0;

    function automatic exp_t blank();
        exp_t e;
        e.zero = 0; e.locked = 0; e.err = 0; e.errcnt = 0; e.chk_pos = 0;
        e.h = 0; e.v = 0; e.chk_len = 0; e.len = 0;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (sample %0d)", name, act, expv, sample_n);
        end
    endtask

    // Monitor: one expected record per consumed input sample
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() != 0) begin
                e = expq.pop_front();
                if (e.zero) begin
                    chk("rst_hpos", int'(o_hpos), 0);
                    chk("rst_vpos", int'(o_vpos), 0);
                    chk("rst_visible", int'(o_visible), 0);
                    chk("rst_frame", int'(o_frame_strobe), 0);
                    chk("rst_locked", int'(o_locked), 0);
                    chk("rst_line_len", int'(o_line_len), 0);
                    chk("rst_err_strobe", int'(o_error_strobe), 0);
                    chk("rst_err_count", int'(o_err_count), 0);
                end else begin
                    chk("locked", int'(o_locked), int'(e.locked));
                    chk("err_strobe", int'(o_error_strobe), int'(e.err));
                    chk("err_count", int'(o_err_count), e.errcnt);
                    if (e.chk_pos) begin
                        chk("hpos", int'(o_hpos), e.h);
                        chk("vpos", int'(o_vpos), e.v);
                        chk("visible", int'(o_visible), int'(e.h < HA && e.v < VA));
                        chk("frame_strobe", int'(o_frame_strobe), int'(e.h == 0 && e.v == 0));
                    end else if (!e.locked) begin
                        chk("visible_unlocked", int'(o_visible), 0);
                        chk("frame_unlocked", int'(o_frame_strobe), 0);
                    end
                    if (e.chk_len) chk("line_len", int'(o_line_len), e.len);
                end
                sample_n++;
            end
        end
    end

    task automatic drive(input bit hs, input bit vs, input bit rst, input exp_t e);
        @(negedge clk);
        i_hsync = hs;
        i_vsync = vs;
        i_reset = rst;
        expq.push_back(e);
    endtask

    // vs_mode: 0 normal (lines VSS..VSS+1), 1 late (line VSS+1 only), 2 off
    task automatic gen_line(input int len, input bit hs_on, input int vs_mode,
                            input int err_gh, input int err_len, input int rst_gh,
                            input bit pos_ok);
        for (int g = 0; g < len; g++) begin
            exp_t e;
            bit hs;
            bit vs;
            e  = blank();
            hs = hs_on && (g >= HSS) && (g < HSS + HSW);
            if (vs_mode == 0)      vs = (gv >= VSS) && (gv <= VSS + 1);
            else if (vs_mode == 1) vs = (gv == VSS + 1);
            else                   vs = 1'b0;
            if (g == rst_gh) begin
                locked_e = 0; errcnt_e = 0; armed = 0;
                e.zero = 1;
                drive(hs, vs, 1'b1, e);
            end else begin
                if (g == err_gh) begin
                    locked_e = 0;
                    errcnt_e = (errcnt_e < 255) ? errcnt_e + 1 : 255;
                    e.err = 1;
                    if (err_len > 0) begin e.chk_len = 1; e.len = err_len; end
                end else if (armed && vs_mode == 0 && gv == VSS && g == 0) begin
                    locked_e = 1; armed = 0;
                end
                e.locked  = locked_e;
                e.errcnt  = errcnt_e;
                e.chk_pos = locked_e && pos_ok;
                e.h = g;
                e.v = gv;
                if (locked_e) begin e.chk_len = 1; e.len = HT; end
                drive(hs, vs, 1'b0, e);
            end
        end
        gv = (gv + 1) % VT;
    endtask

    task automatic normal_lines(input int n);
        for (int i = 0; i < n; i++) gen_line(HT, 1'b1, 0, -1, 0, -1, 1'b1);
    endtask

    // Five 16-clock-spaced edges, vsync edge to lock, then a misplaced hsync
    task automatic error_burst();
        for (int k = 0; k < 70; k++) begin
            exp_t e;
            bit hs;
            e  = blank();
            hs = ((k % HT == 0) && k <= 4 * HT) || (k == 68);
            if (k == 67) begin
                e.locked = 1; e.chk_pos = 1; e.h = 0; e.v = VSS;
                e.chk_len = 1; e.len = HT;
            end else if (k == 68) begin
                errcnt_e = (errcnt_e < 255) ? errcnt_e + 1 : 255;
                e.err = 1;
            end
            e.errcnt = errcnt_e;
            drive(hs, k == 67, 1'b0, e);
        end
    endtask

    initial begin
        exp_t e;
        // Reset state
        e = blank();
        e.zero = 1;
        drive(1'b0, 1'b0, 1'b1, e);
        drive(1'b0, 1'b0, 1'b1, e);

        // Nominal stream: lock at first vsync edge, then three frames
        armed = 1;
        normal_lines(3 * VT);

        // One 15-clock line while locked; relock one frame later
        gen_line(HT - 1, 1'b1, 0, -1, 0, -1, 1'b1);
        gen_line(HT, 1'b1, 0, HSS, HT - 1, -1, 1'b0);
        normal_lines(VT - 2);
        armed = 1;
        normal_lines(VT);

        // Suppressed hsync pulse: error where the counter reaches HSS
        normal_lines(1);
        gen_line(HT, 1'b0, 0, HSS, 0, -1, 1'b1);
        normal_lines(VT - 2);
        armed = 1;
        normal_lines(VT);

        // Vsync one line late
        for (int l = 0; l < VT; l++) gen_line(HT, 1'b1, 1, (l == VT - 1) ? 0 : -1, 0, -1, 1'b1);
        armed = 1;
        normal_lines(VT);

        // One-cycle reset mid-frame while locked
        normal_lines(2);
        gen_line(HT, 1'b1, 0, -1, 0, 5, 1'b1);
        normal_lines(VT - 3);
        armed = 1;
        normal_lines(VT);

        // Hsync held low, then a single pulse: saturated line length
        gen_line(HT, 1'b0, 2, HSS, 0, -1, 1'b1);
        for (int i = 0; i < 126; i++) gen_line(HT, 1'b0, 2, -1, 0, -1, 1'b1);
        e = blank();
        e.errcnt = errcnt_e; e.chk_len = 1; e.len = 1023;
        drive(1'b1, 1'b0, 1'b0, e);
        e = blank();
        e.errcnt = errcnt_e;
        drive(1'b0, 1'b0, 1'b0, e);

        // 299 more errors to saturate the error counter
        for (int i = 0; i < 299; i++) error_burst();

        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        chk("err_count_final", int'(o_err_count), 255);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
